// File: rtl/display_regbank.sv
// Display-board register responder: control/status registers, pixel FIFO
// feeding the panel stream, and a glitch-free backlight PWM.
module display_regbank #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 32,
    parameter int unsigned PW    = 24,
    parameter int unsigned DEPTH = 16,
    parameter logic [31:0] ID    = 32'hD15B_0001
) (
    input  logic          c125,
    input  logic          reset_n,
    input  logic          wvalid,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [PW-1:0] pix_data,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          enable,
    output logic          backlight
);

    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned LW   = PTRW + 1;

    localparam logic [AW-1:0] A_ID      = AW'(8'h00);
    localparam logic [AW-1:0] A_CTRL    = AW'(8'h01);
    localparam logic [AW-1:0] A_STATUS  = AW'(8'h02);
    localparam logic [AW-1:0] A_SCRATCH = AW'(8'h03);
    localparam logic [AW-1:0] A_PIXEL   = AW'(8'h04);

    // Architectural state
    logic [7:0]      duty_q;
    logic [DW-1:0]   scratch_q;
    logic [LW-1:0]   level_q;
    logic [PTRW-1:0] rd_ptr_q;
    logic [PTRW-1:0] wr_ptr_q;
    logic            ovf_q;
    logic            unr_q;
    logic [7:0]      cnt_q;
    logic [7:0]      duty_act_q;
    logic [PW-1:0]   mem [DEPTH];

    // Next-state values
    logic [7:0]      duty_nxt;
    logic [DW-1:0]   scratch_nxt;
    logic [LW-1:0]   level_nxt;
    logic [PTRW-1:0] rd_ptr_nxt;
    logic [PTRW-1:0] wr_ptr_nxt;
    logic            ovf_nxt;
    logic            unr_nxt;
    logic [7:0]      cnt_nxt;
    logic [7:0]      duty_act_nxt;
    logic            enable_nxt;
    logic            pix_valid_nxt;
    logic [PW-1:0]   pix_data_nxt;
    logic            backlight_nxt;
    logic [DW-1:0]   rdata_nxt;

    logic            wr_ctrl;
    logic            wr_status;
    logic            wr_scratch;
    logic            wr_pixel;
    logic            flush;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push;
    logic            ovf_set;
    logic            unr_set;
    logic [DW-1:0]   status_word;
    logic [DW-1:0]   ctrl_word;

    always_comb begin
        wr_ctrl       = 1'b0;
        wr_status     = 1'b0;
        wr_scratch    = 1'b0;
        wr_pixel      = 1'b0;
        flush         = 1'b0;
        full          = 1'b0;
        empty         = 1'b0;
        pop           = 1'b0;
        push          = 1'b0;
        ovf_set       = 1'b0;
        unr_set       = 1'b0;
        duty_nxt      = duty_q;
        enable_nxt    = enable;
        scratch_nxt   = scratch_q;
        level_nxt     = level_q;
        rd_ptr_nxt    = rd_ptr_q;
        wr_ptr_nxt    = wr_ptr_q;
        ovf_nxt       = ovf_q;
        unr_nxt       = unr_q;
        cnt_nxt       = cnt_q + 8'd1;
        duty_act_nxt  = duty_act_q;
        pix_valid_nxt = 1'b0;
        pix_data_nxt  = '0;
        backlight_nxt = 1'b0;
        rdata_nxt     = '0;
        status_word   = '0;
        ctrl_word     = '0;

        wr_ctrl    = wvalid && (addr == A_CTRL);
        wr_status  = wvalid && (addr == A_STATUS);
        wr_scratch = wvalid && (addr == A_SCRATCH);
        wr_pixel   = wvalid && (addr == A_PIXEL);
        flush      = wr_ctrl && wdata[1];

        full  = (level_q == LW'(DEPTH));
        empty = (level_q == '0);

        // A flush discards both the same-cycle pop and push
        pop     = pix_valid && pix_ready && !flush;
        push    = wr_pixel && !flush && (!full || pop);
        ovf_set = wr_pixel && !flush && full && !pop;
        unr_set = pix_ready && enable && empty;

        if (wr_ctrl) begin
            enable_nxt = wdata[0];
            duty_nxt   = wdata[15:8];
        end
        if (wr_scratch) begin
            scratch_nxt = wdata;
        end

        // Sticky flags: a same-cycle set overrides the W1C clear
        ovf_nxt = ovf_set || (ovf_q && !(wr_status && wdata[16]));
        unr_nxt = unr_set || (unr_q && !(wr_status && wdata[17]));

        if (flush) begin
            level_nxt  = '0;
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr_q + PTRW'(1);
            if (pop)  rd_ptr_nxt = rd_ptr_q + PTRW'(1);
            if (push && !pop)      level_nxt = level_q + LW'(1);
            else if (!push && pop) level_nxt = level_q - LW'(1);
        end

        // Head word after this edge; bypass when the push lands at the new head
        if (push && (wr_ptr_q == rd_ptr_nxt)) pix_data_nxt = wdata[PW-1:0];
        else                                  pix_data_nxt = mem[rd_ptr_nxt];
        pix_valid_nxt = enable_nxt && (level_nxt != '0);

        if (cnt_q == 8'hFF) duty_act_nxt = duty_q;
        backlight_nxt = (cnt_nxt < duty_act_nxt);

        status_word[LW-1:0] = level_q;
        status_word[8]      = empty;
        status_word[9]      = full;
        status_word[16]     = ovf_q;
        status_word[17]     = unr_q;
        ctrl_word[0]        = enable;
        ctrl_word[15:8]     = duty_q;

        case (addr)
            A_ID:      rdata_nxt = DW'(ID);
            A_CTRL:    rdata_nxt = ctrl_word;
            A_STATUS:  rdata_nxt = status_word;
            A_SCRATCH: rdata_nxt = scratch_q;
            default:   rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge c125 or negedge reset_n) begin
        if (!reset_n) begin
            duty_q     <= '0;
            enable     <= 1'b0;
            scratch_q  <= '0;
            level_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            unr_q      <= 1'b0;
            cnt_q      <= '0;
            duty_act_q <= '0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            backlight  <= 1'b0;
            rdata      <= '0;
        end else begin
            duty_q     <= duty_nxt;
            enable     <= enable_nxt;
            scratch_q  <= scratch_nxt;
            level_q    <= level_nxt;
            rd_ptr_q   <= rd_ptr_nxt;
            wr_ptr_q   <= wr_ptr_nxt;
            ovf_q      <= ovf_nxt;
            unr_q      <= unr_nxt;
            cnt_q      <= cnt_nxt;
            duty_act_q <= duty_act_nxt;
            pix_valid  <= pix_valid_nxt;
            pix_data   <= pix_data_nxt;
            backlight  <= backlight_nxt;
            rdata      <= rdata_nxt;
        end
    end

    // Pixel storage carries no reset; validity is tracked by level/pointers
    always_ff @(posedge c125) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata[PW-1:0];
        end
    end

endmodule
